// File: rtl/prio_encoder_rr_if.sv
// Request/grant bundle between event sources, the encoder and its single consumer.
interface prio_encoder_rr_if #(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = 3
);
   logic             ei;
   logic [N-1:0]     req;
   logic [IDX_W-1:0] y;
   logic             valid;
   logic             ready;
   logic             gs;
   logic             eo;
   logic [N-1:0]     pend;

   modport master (
      output ei, req, ready,
      input  y, valid, gs, eo, pend
   );

   modport slave (
      input  ei, req, ready,
      output y, valid, gs, eo, pend
   );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with a pending-request latch,
// optional round-robin arbitration and a valid/ready grant handshake.
module prio_encoder_rr #(
   parameter int unsigned N       = 8,
   parameter int unsigned IDX_W   = 3,
   parameter int unsigned RR_MODE = 0
) (
   input logic             clk,
   input logic             rst,
   prio_encoder_rr_if.slave bus
);
   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N - 1);

   logic [N-1:0]     pend_q;
   logic [IDX_W-1:0] y_q;
   logic [IDX_W-1:0] ptr_q;
   logic             valid_q;

   logic [N-1:0]     cand;
   logic [N-1:0]     grant_mask;
   logic [IDX_W-1:0] sel;
   logic             load;

   // Requests only join the candidate set while the encoder is enabled.
   always_comb begin
      cand = pend_q | (bus.ei ? bus.req : '0);
      load = bus.ei & (|cand) & (~valid_q | bus.ready);
   end

   // Winner selection: highest index, or first set bit walking down from ptr with wrap.
   always_comb begin
      logic found;
      int   j;
      sel   = '0;
      found = 1'b0;
      j     = 0;
      if (RR_MODE != 0) begin
         for (int i = 0; i < int'(N); i++) begin
            j = int'(ptr_q) - i;
            if (j < 0) j = j + int'(N);
            if (!found && cand[IDX_W'(j)]) begin
               sel   = IDX_W'(j);
               found = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < int'(N); i++) begin
            if (cand[IDX_W'(i)]) sel = IDX_W'(i);
         end
      end
      grant_mask = {{(N-1){1'b0}}, 1'b1} << sel;
   end

   // A request on the bit granted this cycle is absorbed by clearing it from cand.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q  <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         ptr_q   <= TOP_IDX;
      end else if (load) begin
         y_q     <= sel;
         valid_q <= 1'b1;
         pend_q  <= cand & ~grant_mask;
         if (RR_MODE != 0) begin
            ptr_q <= (sel == '0) ? TOP_IDX : sel - IDX_W'(1);
         end
      end else begin
         pend_q <= cand;
         if (valid_q & bus.ready) valid_q <= 1'b0;
      end
   end

   assign bus.y     = y_q;
   assign bus.valid = valid_q;
   assign bus.gs    = valid_q;
   assign bus.pend  = pend_q;
   assign bus.eo    = bus.ei & ~valid_q & ~(|pend_q) & ~(|bus.req);
endmodule

// File: tb/tb_prio_encoder_rr.sv
// Drives a fixed-priority and a round-robin encoder with the same stimulus and
// compares both against a set-based reference model every cycle.
module tb_prio_encoder_rr;
   localparam int unsigned N     = 8;
   localparam int unsigned IDX_W = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   prio_encoder_rr_if #(.N(N), .IDX_W(IDX_W)) bus0 ();
   prio_encoder_rr_if #(.N(N), .IDX_W(IDX_W)) bus1 ();

   prio_encoder_rr #(.N(N), .IDX_W(IDX_W), .RR_MODE(0)) dut_fix (
      .clk (clk), .rst (rst), .bus (bus0.slave));
   prio_encoder_rr #(.N(N), .IDX_W(IDX_W), .RR_MODE(1)) dut_rr (
      .clk (clk), .rst (rst), .bus (bus1.slave));

   int checks = 0;
   int errors = 0;

   // Reference state per instance: 0 = fixed, 1 = round-robin.
   logic [N-1:0] m_pend  [2];
   int           m_y     [2];
   logic         m_valid [2];
   int           m_last  [2];

   logic         cur_ei;
   logic [N-1:0] cur_req;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Fixed: highest set index. RR: index closest below the last grant, wrapping.
   function automatic int pick(input logic [N-1:0] c, input int mode, input int last);
      int best  = -1;
      int bestd = int'(N);
      int d;
      for (int i = 0; i < int'(N); i++) begin
         if (c[3'(i)]) begin
            if (mode == 0) best = i;
            else begin
               d = ((last - 1 - i) % int'(N) + int'(N)) % int'(N);
               if (d < bestd) begin
                  bestd = d;
                  best  = i;
               end
            end
         end
      end
      return best;
   endfunction

   function automatic logic model_eo(input int d);
      return cur_ei && !m_valid[d] && (m_pend[d] == '0) && (cur_req == '0);
   endfunction

   task automatic model_clock(input logic r, input logic e, input logic [N-1:0] q, input logic rd);
      logic [N-1:0] c;
      int           k;
      for (int d = 0; d < 2; d++) begin
         if (r) begin
            m_pend[d] = '0; m_y[d] = 0; m_valid[d] = 1'b0; m_last[d] = 0;
         end else begin
            c = m_pend[d] | (e ? q : '0);
            if (e && c != '0 && (!m_valid[d] || rd)) begin
               k = pick(c, d, m_last[d]);
               m_y[d]     = k;
               m_valid[d] = 1'b1;
               c[3'(k)]   = 1'b0;
               m_pend[d]  = c;
               m_last[d]  = k;
            end else begin
               if (m_valid[d] && rd) m_valid[d] = 1'b0;
               m_pend[d] = c;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_y0"},  32'(bus0.y),     32'(m_y[0]));
      chk({tag, "_v0"},  32'(bus0.valid), 32'(m_valid[0]));
      chk({tag, "_p0"},  32'(bus0.pend),  32'(m_pend[0]));
      chk({tag, "_g0"},  32'(bus0.gs),    32'(m_valid[0]));
      chk({tag, "_e0"},  32'(bus0.eo),    32'(model_eo(0)));
      chk({tag, "_y1"},  32'(bus1.y),     32'(m_y[1]));
      chk({tag, "_v1"},  32'(bus1.valid), 32'(m_valid[1]));
      chk({tag, "_p1"},  32'(bus1.pend),  32'(m_pend[1]));
      chk({tag, "_g1"},  32'(bus1.gs),    32'(m_valid[1]));
      chk({tag, "_e1"},  32'(bus1.eo),    32'(model_eo(1)));
   endtask

   // One clock: drive at negedge, check eo before the edge, check registers after it.
   task automatic step(input string tag, input logic r, input logic e,
                       input logic [N-1:0] q, input logic rd);
      rst = r; cur_ei = e; cur_req = q;
      bus0.ei = e; bus0.req = q; bus0.ready = rd;
      bus1.ei = e; bus1.req = q; bus1.ready = rd;
      #1;
      chk({tag, "_pre_e0"}, 32'(bus0.eo), 32'(model_eo(0)));
      chk({tag, "_pre_e1"}, 32'(bus1.eo), 32'(model_eo(1)));
      @(posedge clk);
      model_clock(r, e, q, rd);
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   initial begin
      logic         r, e, rd;
      logic [N-1:0] q;
      rst = 1'b1; cur_ei = 1'b1; cur_req = '0;
      bus0.ei = 1'b1; bus0.req = '0; bus0.ready = 1'b0;
      bus1.ei = 1'b1; bus1.req = '0; bus1.ready = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_pend[d] = '0; m_y[d] = 0; m_valid[d] = 1'b0; m_last[d] = 0;
      end
      @(negedge clk);

      // Reset with every request asserted.
      step("rst_a", 1'b1, 1'b1, 8'hFF, 1'b0);
      step("rst_b", 1'b1, 1'b1, 8'hFF, 1'b0);
      chk("rst_y",  32'(bus0.y), 32'd0);
      chk("rst_v",  32'(bus0.valid), 32'd0);
      chk("rst_p",  32'(bus0.pend), 32'd0);
      chk("rst_eo", 32'(bus0.eo), 32'd0);

      // Single pulse of three requests drains highest first.
      step("fx_a", 1'b0, 1'b1, 8'hA4, 1'b1);
      chk("fx_y7", 32'(bus0.y), 32'd7);
      step("fx_b", 1'b0, 1'b1, 8'h00, 1'b1);
      chk("fx_y5", 32'(bus0.y), 32'd5);
      step("fx_c", 1'b0, 1'b1, 8'h00, 1'b1);
      chk("fx_y2", 32'(bus0.y), 32'd2);
      step("fx_d", 1'b0, 1'b1, 8'h00, 1'b1);
      chk("fx_idle_v",  32'(bus0.valid), 32'd0);
      chk("fx_idle_eo", 32'(bus0.eo), 32'd1);

      // Backpressure holds y while new requests accumulate.
      step("bp_a", 1'b0, 1'b1, 8'h01, 1'b0);
      step("bp_b", 1'b0, 1'b1, 8'h80, 1'b0);
      chk("bp_hold_y", 32'(bus0.y), 32'd0);
      chk("bp_pend",   32'(bus0.pend), 32'h80);
      step("bp_c", 1'b0, 1'b1, 8'h00, 1'b1);
      chk("bp_next_y", 32'(bus0.y), 32'd7);
      step("bp_d", 1'b0, 1'b1, 8'h00, 1'b1);

      // All requests held: round-robin cycles down, fixed sticks at 7.
      step("rr_rst", 1'b1, 1'b1, 8'h00, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step("rr", 1'b0, 1'b1, 8'hFF, 1'b1);
         chk("rr_seq", 32'(bus1.y), 32'((7 - i + 16) % 8));
         chk("fx_seq", 32'(bus0.y), 32'd7);
      end

      // Disabled encoder ignores requests and grants nothing.
      step("ei_rst", 1'b1, 1'b1, 8'h00, 1'b1);
      step("ei_off", 1'b0, 1'b0, 8'h10, 1'b1);
      chk("ei_off_v", 32'(bus0.valid), 32'd0);
      chk("ei_off_p", 32'(bus0.pend), 32'd0);
      chk("ei_off_eo", 32'(bus0.eo), 32'd0);
      step("ei_on", 1'b0, 1'b1, 8'h10, 1'b1);
      chk("ei_on_y", 32'(bus0.y), 32'd4);
      step("ei_dr", 1'b0, 1'b1, 8'h00, 1'b1);

      // Request on the bit being granted is absorbed by that grant.
      step("sc_rst", 1'b1, 1'b1, 8'h00, 1'b0);
      step("sc_a", 1'b0, 1'b1, 8'h88, 1'b0);
      chk("sc_pend08", 32'(bus0.pend), 32'h08);
      step("sc_b", 1'b0, 1'b1, 8'h08, 1'b1);
      chk("sc_y3", 32'(bus0.y), 32'd3);
      chk("sc_p0", 32'(bus0.pend), 32'd0);
      step("sc_c", 1'b0, 1'b1, 8'h00, 1'b1);
      chk("sc_once", 32'(bus0.valid), 32'd0);

      // Reset mid-stream clears the grant and restores the RR pointer.
      step("mr_a", 1'b0, 1'b1, 8'h02, 1'b0);
      step("mr_rst", 1'b1, 1'b1, 8'h00, 1'b0);
      chk("mr_v", 32'(bus1.valid), 32'd0);
      step("mr_b", 1'b0, 1'b1, 8'h41, 1'b0);
      chk("mr_ptr", 32'(bus1.y), 32'd6);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 99) == 0);
         e  = ($urandom_range(0, 9) != 0);
         q  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         rd = ($urandom_range(0, 3) != 0);
         step("rnd", r, e, q, rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
